// File: rtl/cpu_pipe_pkg.sv
// Shared fetch/decode pipeline types: packet layout, machine width and the NOP word.
package cpu_pipe_pkg;

    localparam int XLEN = 32;

    // MIPS sll $0,$0,0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_4;
        logic [XLEN-1:0] instruction;
    } fetch_pkt_t;

endpackage

// File: rtl/if_id_slot.sv
// One fetch packet register with load enable and asynchronous active-low clear.
module if_id_slot
    import cpu_pipe_pkg::*;
(
    input  logic       clock,
    input  logic       rst_n,
    input  logic       load,
    input  fetch_pkt_t d,
    output fetch_pkt_t q
);

    fetch_pkt_t pkt_q;
    fetch_pkt_t pkt_d;

    always_comb begin
        pkt_d = pkt_q;
        if (load) begin
            pkt_d = d;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q <= '0;
        end else begin
            pkt_q <= pkt_d;
        end
    end

    assign q = pkt_q;

endmodule

// File: rtl/if_id_buffer.sv
// Fetch-to-decode buffer. IF_ID_SKID_EN selects the two-entry skid buffer
// (fully registered if_ready); otherwise a single register with ready passed through from decode.
module if_id_buffer #(
    parameter int                XLEN      = cpu_pipe_pkg::XLEN,
    parameter logic [XLEN-1:0]   NOP_INSTR = cpu_pipe_pkg::NOP_INSTR
) (
    input  logic            clock,
    input  logic            cpu_rst_n,
    input  logic            cpu_en,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_pc_4,
    input  logic [XLEN-1:0] if_instruction,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_4,
    output logic [XLEN-1:0] id_instruction,
    output logic [1:0]      occupancy
);

    cpu_pipe_pkg::fetch_pkt_t in_pkt;
    cpu_pipe_pkg::fetch_pkt_t head_pkt;
    logic accept;
    logic pop;
    logic head_load;

    assign in_pkt = '{pc: if_pc, pc_4: if_pc_4, instruction: if_instruction};
    assign accept = if_valid & if_ready & ~flush;
    assign pop    = id_valid & id_ready;

`ifdef IF_ID_SKID_EN
    logic [1:0]               occ_q;
    logic [1:0]               occ_d;
    logic                     tail_load;
    cpu_pipe_pkg::fetch_pkt_t tail_pkt;
    cpu_pipe_pkg::fetch_pkt_t head_in;

    // Ready depends only on stored occupancy, so decode stalls never reach fetch combinationally.
    assign if_ready = cpu_rst_n & cpu_en & (occ_q != cpu_pipe_pkg::OCC_FULL);

    always_comb begin
        occ_d     = occ_q;
        head_load = 1'b0;
        tail_load = 1'b0;
        head_in   = in_pkt;
        if (cpu_en) begin
            if (flush) begin
                occ_d = cpu_pipe_pkg::OCC_EMPTY;
            end else begin
                case (occ_q)
                    cpu_pipe_pkg::OCC_EMPTY: begin
                        if (accept) begin
                            head_load = 1'b1;
                            occ_d     = cpu_pipe_pkg::OCC_ONE;
                        end
                    end
                    cpu_pipe_pkg::OCC_ONE: begin
                        if (accept && pop) begin
                            head_load = 1'b1;
                        end else if (accept) begin
                            tail_load = 1'b1;
                            occ_d     = cpu_pipe_pkg::OCC_FULL;
                        end else if (pop) begin
                            occ_d = cpu_pipe_pkg::OCC_EMPTY;
                        end
                    end
                    cpu_pipe_pkg::OCC_FULL: begin
                        if (pop) begin
                            head_in   = tail_pkt;
                            head_load = 1'b1;
                            occ_d     = cpu_pipe_pkg::OCC_ONE;
                        end
                    end
                    default: occ_d = cpu_pipe_pkg::OCC_EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            occ_q <= cpu_pipe_pkg::OCC_EMPTY;
        end else begin
            occ_q <= occ_d;
        end
    end

    if_id_slot u_head (
        .clock (clock),
        .rst_n (cpu_rst_n),
        .load  (head_load),
        .d     (head_in),
        .q     (head_pkt)
    );

    if_id_slot u_tail (
        .clock (clock),
        .rst_n (cpu_rst_n),
        .load  (tail_load),
        .d     (in_pkt),
        .q     (tail_pkt)
    );

    assign occupancy = occ_q;
`else
    logic occ_q;
    logic occ_d;

    // A full register can still take a packet when decode drains it in the same cycle.
    assign if_ready = cpu_rst_n & cpu_en & (~occ_q | id_ready);

    always_comb begin
        occ_d     = occ_q;
        head_load = 1'b0;
        if (cpu_en) begin
            if (flush) begin
                occ_d = 1'b0;
            end else if (accept) begin
                head_load = 1'b1;
                occ_d     = 1'b1;
            end else if (pop) begin
                occ_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            occ_q <= 1'b0;
        end else begin
            occ_q <= occ_d;
        end
    end

    if_id_slot u_head (
        .clock (clock),
        .rst_n (cpu_rst_n),
        .load  (head_load),
        .d     (in_pkt),
        .q     (head_pkt)
    );

    assign occupancy = {1'b0, occ_q};
`endif

    assign id_valid       = cpu_en & (occupancy != cpu_pipe_pkg::OCC_EMPTY);
    assign id_pc          = head_pkt.pc;
    assign id_pc_4        = head_pkt.pc_4;
    assign id_instruction = id_valid ? head_pkt.instruction : NOP_INSTR;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed, table-driven bench for if_id_buffer; expectations follow the build's IF_ID_SKID_EN setting.
module tb_if_id_buffer;

    logic        clock;
    logic        cpu_rst_n;
    logic        cpu_en;
    logic        flush;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_pc_4;
    logic [31:0] if_instruction;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_pc_4;
    logic [31:0] id_instruction;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    if_id_buffer dut (
        .clock          (clock),
        .cpu_rst_n      (cpu_rst_n),
        .cpu_en         (cpu_en),
        .flush          (flush),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_pc_4        (if_pc_4),
        .if_instruction (if_instruction),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_pc_4        (id_pc_4),
        .id_instruction (id_instruction),
        .occupancy      (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs for the current cycle, and the outputs required just before its rising edge.
    typedef struct {
        logic        fl;
        logic        v;
        logic [31:0] pc;
        logic        rdy;
        logic        en;
        logic [1:0]  occ;
        logic        idv;
        logic [31:0] idpc;
        logic        ifr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic add(input logic fl, input logic v, input logic [31:0] pc, input logic rdy,
                       input logic en, input logic [1:0] occ, input logic idv,
                       input logic [31:0] idpc, input logic ifr);
        vec_t r;
        r.fl = fl; r.v = v; r.pc = pc; r.rdy = rdy; r.en = en;
        r.occ = occ; r.idv = idv; r.idpc = idpc; r.ifr = ifr;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic v, input logic [31:0] pc,
                         input logic rdy, input logic en);
        flush          = fl;
        if_valid       = v;
        if_pc          = pc;
        if_pc_4        = pc + 32'd4;
        if_instruction = instr_of(pc);
        id_ready       = rdy;
        cpu_en         = en;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".occupancy"}, {30'd0, occupancy}, 32'd0);
        check({tag, ".id_valid"},  {31'd0, id_valid},  32'd0);
        check({tag, ".if_ready"},  {31'd0, if_ready},  32'd0);
        check({tag, ".id_pc"},     id_pc,              32'd0);
        check({tag, ".id_pc_4"},   id_pc_4,            32'd0);
        check({tag, ".id_instr"},  id_instruction,     32'h0000_0000);
    endtask

    initial begin
        logic [1:0] full_occ;
        logic [31:0] exp_instr;

`ifdef IF_ID_SKID_EN
        full_occ = 2'd2;
        //   fl v  pc     rdy en | occ  idv idpc   ifr
        add(0, 1, 32'h00, 1, 1,   2'd0, 0, 32'h00, 1);
        add(0, 1, 32'h04, 1, 1,   2'd1, 1, 32'h00, 1);
        add(0, 1, 32'h08, 1, 1,   2'd1, 1, 32'h04, 1);
        add(0, 0, 32'h00, 1, 1,   2'd1, 1, 32'h08, 1);
        add(0, 1, 32'h10, 0, 1,   2'd0, 0, 32'h08, 1);
        add(0, 1, 32'h14, 0, 1,   2'd1, 1, 32'h10, 1);
        add(0, 1, 32'h18, 0, 1,   2'd2, 1, 32'h10, 0);
        add(0, 1, 32'h18, 1, 1,   2'd2, 1, 32'h10, 0);
        add(0, 0, 32'h00, 1, 1,   2'd1, 1, 32'h14, 1);
        add(0, 0, 32'h00, 0, 1,   2'd0, 0, 32'h14, 1);
        add(0, 1, 32'h30, 0, 1,   2'd0, 0, 32'h14, 1);
        add(0, 1, 32'h34, 0, 1,   2'd1, 1, 32'h30, 1);
        add(1, 1, 32'h20, 1, 1,   2'd2, 1, 32'h30, 0);
        add(0, 0, 32'h00, 0, 1,   2'd0, 0, 32'h30, 1);
        add(0, 1, 32'h40, 0, 1,   2'd0, 0, 32'h30, 1);
        add(0, 1, 32'h44, 1, 0,   2'd1, 0, 32'h40, 0);
        add(0, 1, 32'h44, 1, 0,   2'd1, 0, 32'h40, 0);
        add(0, 1, 32'h44, 1, 0,   2'd1, 0, 32'h40, 0);
        add(0, 0, 32'h00, 0, 1,   2'd1, 1, 32'h40, 1);
        add(0, 0, 32'h00, 1, 1,   2'd1, 1, 32'h40, 1);
        add(0, 0, 32'h00, 0, 1,   2'd0, 0, 32'h40, 1);
`else
        full_occ = 2'd1;
        add(0, 1, 32'h00, 1, 1,   2'd0, 0, 32'h00, 1);
        add(0, 1, 32'h04, 1, 1,   2'd1, 1, 32'h00, 1);
        add(0, 1, 32'h08, 1, 1,   2'd1, 1, 32'h04, 1);
        add(0, 0, 32'h00, 1, 1,   2'd1, 1, 32'h08, 1);
        add(0, 1, 32'h10, 0, 1,   2'd0, 0, 32'h08, 1);
        add(0, 1, 32'h14, 0, 1,   2'd1, 1, 32'h10, 0);
        add(0, 1, 32'h14, 1, 1,   2'd1, 1, 32'h10, 1);
        add(0, 0, 32'h00, 0, 1,   2'd1, 1, 32'h14, 0);
        add(1, 1, 32'h20, 1, 1,   2'd1, 1, 32'h14, 1);
        add(0, 0, 32'h00, 0, 1,   2'd0, 0, 32'h14, 1);
        add(0, 1, 32'h40, 0, 1,   2'd0, 0, 32'h14, 1);
        add(0, 1, 32'h44, 1, 0,   2'd1, 0, 32'h40, 0);
        add(0, 1, 32'h44, 1, 0,   2'd1, 0, 32'h40, 0);
        add(0, 1, 32'h44, 1, 0,   2'd1, 0, 32'h40, 0);
        add(0, 0, 32'h00, 0, 1,   2'd1, 1, 32'h40, 0);
        add(0, 0, 32'h00, 1, 1,   2'd1, 1, 32'h40, 1);
        add(0, 0, 32'h00, 0, 1,   2'd0, 0, 32'h40, 1);
`endif

        // Reset with enable high: if_ready must still be low while reset is asserted.
        cpu_rst_n = 1'b1;
        drive(0, 0, 32'h0, 0, 1);
        #1 cpu_rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        @(negedge clock);
        cpu_rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].fl, vecs[i].v, vecs[i].pc, vecs[i].rdy, vecs[i].en);
            #1;
            exp_instr = vecs[i].idv ? instr_of(vecs[i].idpc) : 32'h0000_0000;
            check($sformatf("v%0d.occupancy", i), {30'd0, occupancy}, {30'd0, vecs[i].occ});
            check($sformatf("v%0d.id_valid", i),  {31'd0, id_valid},  {31'd0, vecs[i].idv});
            check($sformatf("v%0d.id_pc", i),     id_pc,              vecs[i].idpc);
            check($sformatf("v%0d.if_ready", i),  {31'd0, if_ready},  {31'd0, vecs[i].ifr});
            check($sformatf("v%0d.id_instr", i),  id_instruction,     exp_instr);
            if (vecs[i].idv) begin
                check($sformatf("v%0d.id_pc_4", i), id_pc_4, vecs[i].idpc + 32'd4);
            end
            $display("vec %0d: fl=%0b v=%0b pc=0x%0h rdy=%0b en=%0b -> occ=%0d idv=%0b id_pc=0x%0h ifr=%0b",
                     i, vecs[i].fl, vecs[i].v, vecs[i].pc, vecs[i].rdy, vecs[i].en,
                     occupancy, id_valid, id_pc, if_ready);
        end

        // Fill to capacity, then assert reset between clock edges.
        @(negedge clock);
        drive(0, 1, 32'h50, 0, 1);
        @(negedge clock);
        drive(0, 1, 32'h54, 0, 1);
        @(negedge clock);
        drive(0, 0, 32'h0, 0, 1);
        #1;
        check("fill.occupancy", {30'd0, occupancy}, {30'd0, full_occ});
        check("fill.id_pc", id_pc, 32'h50);
        #1 cpu_rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        $display("async reset mid-cycle: occ=%0d idv=%0b ifr=%0b id_pc=0x%0h",
                 occupancy, id_valid, if_ready, id_pc);
        @(negedge clock);
        cpu_rst_n = 1'b1;
        #1;
        check("post_rst.if_ready", {31'd0, if_ready}, 32'd1);
        check("post_rst.occupancy", {30'd0, occupancy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Fetch-to-decode pipeline buffer. Sits directly downstream of the fetch stage and upstream of decode. Captures each fetched packet (pc, pc+4, instruction) under a valid/ready handshake and holds up to two packets so decode backpressure never combinationally reaches fetch. A branch/jump flush discards all buffered packets and the packet offered in the same cycle.

## Interface
Parameters:
- `XLEN`, 32, address/instruction width.
- `NOP_INSTR`, 32'h0000_0000, instruction driven to decode when no valid packet (MIPS `sll $0,$0,0`).

Ports:
- `clock`  in  1  system clock, rising edge.
- `cpu_rst_n`  in  1  reset, asynchronous, active-low.
- `cpu_en`  in  1  global enable; 0 freezes all state.
- `flush`  in  1  branch/jump taken; discard contents.
- `if_valid`  in  1  fetch offers a packet.
- `if_ready`  out  1  buffer can accept.
- `if_pc`  in  XLEN  pc of fetched instruction.
- `if_pc_4`  in  XLEN  pc+4 from fetch.
- `if_instruction`  in  XLEN  fetched word.
- `id_valid`  out  1  packet presented to decode.
- `id_ready`  in  1  decode consumes.
- `id_pc`, `id_pc_4`, `id_instruction`  out  XLEN each  head packet.
- `occupancy`  out  2  number of buffered packets (0..2).

## Operation
- Accept = `if_valid & if_ready & ~flush`. Pop = `id_valid & id_ready`.
- `if_ready = cpu_en & (occupancy != 2)`; driven from registered state only, with no path from `id_ready`.
- `id_valid = cpu_en & (occupancy != 0)`.
- Head entry drives `id_*`. When `id_valid=0`, `id_instruction = NOP_INSTR`; `id_pc`/`id_pc_4` hold their last head value (0 after reset).
- Occupancy transitions:
  - 0 with accept → 1.
  - 1 with accept only → 2; tail written.
  - 1 with pop only → 0.
  - 1 with accept and pop → 1; the new packet becomes head.
  - 2 with pop → 1; tail moves to head.
  - Accept is impossible at 2 because ready is low.
- Flush has priority over everything. On the next edge occupancy is 0 and the same-cycle input is dropped. A same-cycle pop still counts as consumed by decode.
- `cpu_en=0`: no state changes; `if_ready` and `id_valid` are low.
- Reset, asserted any time including mid-transfer: occupancy 0, `id_valid` 0, `if_ready` 0 while asserted, `id_pc`/`id_pc_4` 0, `id_instruction` `NOP_INSTR`. Buffered packets are lost.

## Timing
- Latency: a packet accepted at edge N is visible on `id_*` with `id_valid=1` after edge N (one cycle).
- Throughput: one packet per cycle sustained while `id_ready=1`.
- `if_ready` deasserts in the cycle after occupancy reaches 2 and reasserts in the cycle after the first pop.
- `flush` asserted in cycle N gives `id_valid=0` in cycle N+1. `if_ready` is 1 in cycle N+1 if `cpu_en` is high.
- All outputs are registered, except the `cpu_en` gating and the `NOP_INSTR` mux.

## Configuration
- `IF_ID_SKID_EN` defined: two-entry skid behaviour as above.
- Not defined: single-entry register; occupancy is 0..1 and bit 1 is tied 0.
  - `if_ready = cpu_en & (occupancy==0 | id_ready)`, which is a combinational path from `id_ready`.
  - Accept plus pop at occupancy 1 replaces the head.
  - Flush, reset and `cpu_en` rules are unchanged.

## Structure
- Shared package `cpu_pipe_pkg`:
  - `fetch_pkt_t` struct {pc, pc_4, instruction}.
  - `NOP_INSTR` constant.
  - `XLEN`.
- One sub-module `if_id_slot`: a `fetch_pkt_t` register with load enable and asynchronous active-low clear. Instantiate it twice (head, tail) with `IF_ID_SKID_EN`, once without.

## Test plan
- Reset, then `if_valid=1` with pc 0x0, 0x4, 0x8 and `id_ready=1` → `id_pc` shows 0x0, 0x4, 0x8 on consecutive cycles, starting one cycle after each accept; `occupancy` stays at 1.
- Hold `id_ready=0` and offer 0x10, 0x14, 0x18 → `occupancy=2`, `if_ready=0`, and 0x18 is not accepted. Raise `id_ready` → decode sees 0x10 then 0x14 in order.
- `occupancy=2` and `flush=1` with `if_valid=1` for pc 0x20 → next cycle `id_valid=0`, `id_instruction=0x00000000`, `occupancy=0`, and 0x20 is never delivered.
- Drop `cpu_en` for 3 cycles with one packet buffered → `id_valid=0`, `if_ready=0`, and the packet is unchanged. Re-enable → the same packet is presented.
- Assert `cpu_rst_n=0` mid-cycle with 2 packets buffered → outputs go to reset values immediately, asynchronously.
- Build without `IF_ID_SKID_EN`, `occupancy=1`, `id_ready=1`, new `if_valid` → accepted in the same cycle with zero bubble; `if_ready` follows `id_ready` combinationally.
